// File: rtl/hazard_ctrl_sb.sv
// Scoreboard-based hazard unit for the 5-stage RISC-V pipeline: forwarding selects,
// load/multi-cycle-use interlocks, out-of-order mul/div write-back tracking and stall counting.
module hazard_ctrl_sb #(
    parameter int unsigned NREGS          = 32,
    parameter int unsigned MC_OUTSTANDING = 2,
    parameter int unsigned CNT_W          = 16,
    localparam int unsigned AW            = $clog2(NREGS),
    localparam int unsigned CW            = $clog2(MC_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    a1_d,
    input  logic [AW-1:0]    a2_d,
    input  logic [AW-1:0]    a3_d,
    input  logic             use_a1_d,
    input  logic             use_a2_d,
    input  logic             rf_we_d,
    input  logic             mc_start_d,
    input  logic [AW-1:0]    a1_e,
    input  logic [AW-1:0]    a2_e,
    input  logic [AW-1:0]    a3_e,
    input  logic             rf_we_e,
    input  logic             load_e,
    input  logic             mc_start_e,
    input  logic             pc_redirect_e,
    input  logic [AW-1:0]    a3_m,
    input  logic [AW-1:0]    a3_w,
    input  logic             rf_we_m,
    input  logic             rf_we_w,
    input  logic             mem_wait,
    input  logic             mc_done,
    input  logic [AW-1:0]    mc_dst,
    output logic [1:0]       fw_a,
    output logic [1:0]       fw_b,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             mc_issue,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [NREGS-1:0] pending;
    logic [CW-1:0]    count;
    logic [CW:0]      inflight;
    logic             issue, done_ok, lu, sb, st, hz;

    // E-stage write enable is not needed: loads and mc ops always write their a3.
    logic unused_rf_we_e;
    assign unused_rf_we_e = rf_we_e;

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] a, input logic [AW-1:0] dm,
                                           input logic [AW-1:0] dw, input logic wem,
                                           input logic wew);
        if (a == '0)
            return 2'd0;
        if (wem && a == dm)
            return 2'd1;
        if (wew && a == dw)
            return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        issue    = mc_start_e & ~mem_wait;
        done_ok  = mc_done & (count != '0);
        lu       = (load_e | mc_start_e) & (a3_e != '0) &
                   ((use_a1_d & (a1_d == a3_e)) | (use_a2_d & (a2_d == a3_e)));
        sb       = (use_a1_d & pending[a1_d]) | (use_a2_d & pending[a2_d]) |
                   (rf_we_d & pending[a3_d]);
        inflight = {1'b0, count} + {{CW{1'b0}}, issue};
        st       = mc_start_d & (inflight >= (CW+1)'(MC_OUTSTANDING));
        hz       = lu | sb | st;

        fw_a     = 2'd0;
        fw_b     = 2'd0;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_w  = 1'b0;
        mc_issue = 1'b0;
        mc_busy  = 1'b0;

        if (!rst) begin
            fw_a     = fwd_sel(a1_e, a3_m, a3_w, rf_we_m, rf_we_w);
            fw_b     = fwd_sel(a2_e, a3_m, a3_w, rf_we_m, rf_we_w);
            mc_issue = issue;
            mc_busy  = (count != '0);
            if (mem_wait) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (pc_redirect_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (hz) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // Set is applied after clear so a same-index issue/done leaves the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            count     <= '0;
            stall_cnt <= '0;
        end else begin
            if (done_ok)
                pending[mc_dst] <= 1'b0;
            if (issue && a3_e != '0)
                pending[a3_e] <= 1'b1;
            case ({issue, done_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (stall_f && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Directed-vector bench for hazard_ctrl_sb: the driver queues hand-computed expectations,
// an independent monitor pops and checks them on the falling edge.
module tb_hazard_ctrl_sb;

    localparam logic [6:0] S_NONE = 7'b0000000; // {sf,sd,se,sm,fd,fe,fw}
    localparam logic [6:0] S_HZ   = 7'b1100010;
    localparam logic [6:0] S_MEM  = 7'b1111001;
    localparam logic [6:0] S_RED  = 7'b0000110;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  a1_d, a2_d, a3_d, a1_e, a2_e, a3_e, a3_m, a3_w, mc_dst;
    logic        use_a1_d, use_a2_d, rf_we_d, mc_start_d;
    logic        rf_we_e, load_e, mc_start_e, pc_redirect_e;
    logic        rf_we_m, rf_we_w, mem_wait, mc_done;
    logic [1:0]  fw_a, fw_b;
    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic        mc_issue, mc_busy;
    logic [15:0] stall_cnt;

    typedef struct {
        string       name;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [6:0]  sf;
        logic        iss;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_sb #(.NREGS(32), .MC_OUTSTANDING(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .a1_d(a1_d), .a2_d(a2_d), .a3_d(a3_d),
        .use_a1_d(use_a1_d), .use_a2_d(use_a2_d), .rf_we_d(rf_we_d), .mc_start_d(mc_start_d),
        .a1_e(a1_e), .a2_e(a2_e), .a3_e(a3_e),
        .rf_we_e(rf_we_e), .load_e(load_e), .mc_start_e(mc_start_e), .pc_redirect_e(pc_redirect_e),
        .a3_m(a3_m), .a3_w(a3_w), .rf_we_m(rf_we_m), .rf_we_w(rf_we_w),
        .mem_wait(mem_wait), .mc_done(mc_done), .mc_dst(mc_dst),
        .fw_a(fw_a), .fw_b(fw_b),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .mc_issue(mc_issue), .mc_busy(mc_busy), .stall_cnt(stall_cnt)
    );

    task automatic clear_in();
        a1_d = '0; a2_d = '0; a3_d = '0; a1_e = '0; a2_e = '0; a3_e = '0;
        a3_m = '0; a3_w = '0; mc_dst = '0;
        use_a1_d = 0; use_a2_d = 0; rf_we_d = 0; mc_start_d = 0;
        rf_we_e = 0; load_e = 0; mc_start_e = 0; pc_redirect_e = 0;
        rf_we_m = 0; rf_we_w = 0; mem_wait = 0; mc_done = 0;
    endtask

    // Inputs are already applied; queue the expected response and advance one cycle.
    task automatic chk(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [6:0] sf, input logic iss, input logic busy,
                       input logic [15:0] cnt);
        exp_t e;
        e.name = nm; e.fa = fa; e.fb = fb; e.sf = sf; e.iss = iss; e.busy = busy; e.cnt = cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [6:0]  sf_act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                sf_act = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
                n_checks++;
                if (fw_a !== e.fa || fw_b !== e.fb || sf_act !== e.sf ||
                    mc_issue !== e.iss || mc_busy !== e.busy || stall_cnt !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s: got fw_a=%0d fw_b=%0d sf=%b iss=%b busy=%b cnt=%0d, want fw_a=%0d fw_b=%0d sf=%b iss=%b busy=%b cnt=%0d",
                             e.name, fw_a, fw_b, sf_act, mc_issue, mc_busy, stall_cnt,
                             e.fa, e.fb, e.sf, e.iss, e.busy, e.cnt);
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        clear_in();
        @(posedge clk);
        #1;

        // Reset with hazardous inputs: all outputs forced low
        rf_we_m = 1; a3_m = 5; a1_e = 5; load_e = 1; a3_e = 7; a2_d = 7; use_a2_d = 1;
        chk("reset", 0, 0, S_NONE, 0, 0, 0);
        rst = 1'b0;

        // Forwarding
        clear_in(); rf_we_m = 1; a3_m = 5; rf_we_w = 1; a3_w = 5; a1_e = 5; a2_e = 3;
        chk("fwd_m", 1, 0, S_NONE, 0, 0, 0);
        rf_we_m = 0; a2_e = 5;
        chk("fwd_w", 2, 2, S_NONE, 0, 0, 0);
        clear_in(); rf_we_m = 1; rf_we_w = 1;
        chk("fwd_x0", 0, 0, S_NONE, 0, 0, 0);

        // Load-use
        clear_in(); load_e = 1; a3_e = 7; a2_d = 7; use_a2_d = 1;
        chk("lu_a2", 0, 0, S_HZ, 0, 0, 0);
        load_e = 0; a3_e = 0;
        chk("lu_release", 0, 0, S_NONE, 0, 0, 1);
        clear_in(); load_e = 1; a3_e = 0; a2_d = 0; use_a2_d = 1;
        chk("lu_x0", 0, 0, S_NONE, 0, 0, 1);
        clear_in(); load_e = 1; a3_e = 7; a2_d = 7; use_a2_d = 0;
        chk("lu_unused", 0, 0, S_NONE, 0, 0, 1);
        clear_in(); load_e = 1; a3_e = 7; a1_d = 7; use_a1_d = 1;
        chk("lu_a1", 0, 0, S_HZ, 0, 0, 1);

        // Scoreboard: div to x9, dependent reader waits for mc_done
        clear_in(); mc_start_e = 1; a3_e = 9; a1_d = 9; use_a1_d = 1;
        chk("sb_issue", 0, 0, S_HZ, 1, 0, 2);
        mc_start_e = 0; a3_e = 0;
        chk("sb_wait", 0, 0, S_HZ, 0, 1, 3);
        mc_done = 1; mc_dst = 9;
        chk("sb_done", 0, 0, S_HZ, 0, 1, 4);
        mc_done = 0; mc_dst = 0;
        chk("sb_go", 0, 0, S_NONE, 0, 0, 5);

        // Structural limit
        clear_in(); mc_start_e = 1; a3_e = 10; mc_start_d = 1; rf_we_d = 1; a3_d = 11;
        chk("st_first", 0, 0, S_NONE, 1, 0, 5);
        a3_e = 11; a3_d = 12;
        chk("st_full", 0, 0, S_HZ, 1, 1, 5);
        mc_start_e = 0; a3_e = 0;
        chk("st_hold", 0, 0, S_HZ, 0, 1, 6);
        clear_in(); mc_start_e = 1; a3_e = 13; mc_done = 1; mc_dst = 10;
        chk("st_iss_done", 0, 0, S_NONE, 1, 1, 7);
        clear_in(); mc_start_d = 1;
        chk("st_count2", 0, 0, S_HZ, 0, 1, 7);
        clear_in(); rf_we_d = 1; a3_d = 13;
        chk("sb_waw", 0, 0, S_HZ, 0, 1, 8);
        clear_in(); mc_done = 1; mc_dst = 11;
        chk("sb_drain", 0, 0, S_NONE, 0, 1, 9);

        // Reset with count == 1 outstanding (x13)
        clear_in(); rst = 1; use_a1_d = 1; a1_d = 13; rf_we_m = 1; a3_m = 4; a1_e = 4;
        chk("rst_mid", 0, 0, S_NONE, 0, 0, 0);
        rst = 0;
        clear_in(); mc_done = 1; mc_dst = 13; use_a1_d = 1; a1_d = 13;
        chk("rst_late_done", 0, 0, S_NONE, 0, 0, 0);
        clear_in(); mc_start_d = 1; mc_start_e = 1; a3_e = 14;
        chk("no_underflow", 0, 0, S_NONE, 1, 0, 0);

        // Priority
        clear_in(); mem_wait = 1; pc_redirect_e = 1; load_e = 1; a3_e = 7; a1_d = 7; use_a1_d = 1;
        chk("prio_mem", 0, 0, S_MEM, 0, 1, 0);
        clear_in(); mem_wait = 1; mc_start_e = 1; a3_e = 15;
        chk("mem_no_issue", 0, 0, S_MEM, 0, 1, 1);
        clear_in(); pc_redirect_e = 1; load_e = 1; a3_e = 7; a1_d = 7; use_a1_d = 1;
        chk("prio_redirect", 0, 0, S_RED, 0, 1, 2);
        clear_in(); mc_start_d = 1;
        chk("count_after_mem", 0, 0, S_NONE, 0, 1, 2);

        clear_in();
        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_sb.md
# hazard_ctrl_sb

Scoreboard-based hazard unit for the 5-stage RISC-V pipeline, the successor to the purely combinational hazard controller. It adds:

- tracking of up to `MC_OUTSTANDING` in-flight multi-cycle (mul/div) ops that write back out of order through their own port;
- data-memory wait freezing;
- a structural stall when the multi-cycle unit is full;
- x0-aware load-use detection;
- a saturating stall-cycle counter.

It sits beside the datapath, driving the per-stage stall/flush enables and the two E-stage forwarding muxes.

## Interface
Parameters:
- `NREGS`, 32: architectural register count; `AW = $clog2(NREGS)`.
- `MC_OUTSTANDING`, 2: maximum in-flight multi-cycle ops; `CW = $clog2(MC_OUTSTANDING+1)`.
- `CNT_W`, 16: width of `stall_cnt`.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock. One clock; reset is asynchronous and active-high.
- `rst`  in  1  asynchronous, active-high reset.
- `a1_d`, `a2_d`, `a3_d`  in  AW  D-stage source 1, source 2 and destination register indices.
- `use_a1_d`, `use_a2_d`, `rf_we_d`  in  1  D instruction reads a1 / reads a2 / writes a3.
- `mc_start_d`  in  1  D instruction is a multi-cycle op.
- `a1_e`, `a2_e`, `a3_e`  in  AW  E-stage register indices.
- `rf_we_e`  in  1  E instruction writes a3 through the pipeline.
- `load_e`  in  1  E instruction is a load.
- `mc_start_e`  in  1  E instruction is a multi-cycle op.
- `pc_redirect_e`  in  1  branch/jump taken in E.
- `a3_m`, `a3_w`  in  AW  M-stage and W-stage destinations.
- `rf_we_m`, `rf_we_w`  in  1  M-stage and W-stage write enables.
- `mem_wait`  in  1  data memory not ready in M.
- `mc_done`  in  1  the multi-cycle unit writes back this cycle.
- `mc_dst`  in  AW  destination of that write-back.
- `fw_a`, `fw_b`  out  2  forwarding select: 0 none, 1 M stage, 2 W stage.
- `stall_f`, `stall_d`, `stall_e`, `stall_m`  out  1  hold the pipeline register feeding each stage.
- `flush_d`, `flush_e`, `flush_w`  out  1  insert a bubble into the stage.
- `mc_issue`  out  1  start strobe to the multi-cycle unit.
- `mc_busy`  out  1  outstanding count is non-zero.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `stall_f` high.

## Operation
State:
- `pending[NREGS-1:0]`
- `count[CW-1:0]`
- `stall_cnt`

All three reset to 0.

Forwarding, computed per source independently:
- Select M when `rf_we_m` and `a_e == a3_m`.
- Otherwise select W when `rf_we_w` and `a_e == a3_w`.
- Otherwise select none.
- Index 0 is never forwarded.
- Multi-cycle results are never forwarded; they are covered by the scoreboard.

Hazard terms (a "match" requires a non-zero index):
- `lu`: `(load_e | mc_start_e)` and `a3_e` matches a used D source.
- `sb`: a used D source has its pending bit set, or `rf_we_d & pending[a3_d]` (WAW).
- `st`: `mc_start_d` and `count + mc_issue >= MC_OUTSTANDING`.
- `hz = lu | sb | st`.

Priority, highest first:
1. `mem_wait`: `stall_f`, `stall_d`, `stall_e` and `stall_m` high; `flush_w` high; all other outputs low.
2. `pc_redirect_e`: `flush_d` and `flush_e` high; `stall_f` and `stall_d` low. Redirect overrides `hz`.
3. `hz`: `stall_f` and `stall_d` high; `flush_e` high.
4. Otherwise all stall/flush outputs are low.

Scoreboard:
- `mc_issue = mc_start_e & ~mem_wait`.
- On `mc_issue`: set `pending[a3_e]` (unless `a3_e` is 0) and increment `count`.
- On `mc_done`: clear `pending[mc_dst]` and decrement `count`.
- Issue and done in the same cycle: `count` unchanged. If the indices are equal, the set wins; WAW stalling makes this unreachable.
- `mc_done` with `count == 0` is ignored (no underflow).

Counter:
- `stall_cnt` increments when `stall_f` is high.
- It saturates at all-ones.

## Timing
- All hazard outputs are combinational from inputs and state, with no added latency.
- A `pending` bit is set at the edge that ends the issue cycle. The dependent instruction in D is held by `lu` during the issue cycle and by `sb` afterwards.
- A `pending` bit clears at the edge ending the `mc_done` cycle. The dependent instruction leaves D on the following cycle and reads the register file.
- While `rst` is high, every output is 0 and state is held at reset. Reset during an outstanding op discards it; a later `mc_done` is ignored by the count == 0 rule.

## Test plan
- Forwarding: add writes x5 in M, add writes x5 in W, E reads x5 as a1 → `fw_a = 1`. Clear `rf_we_m` → `fw_a = 2`. With `a1_e = 0` under any writes → `fw_a = 0`.
- Load-use: `load_e`, `a3_e = 7`, `a2_d = 7` with `use_a2_d = 1` → exactly one cycle of `stall_f`/`stall_d`/`flush_e`. Same case with `a3_e = 0`, or with `use_a2_d = 0` → no stall.
- Scoreboard: issue div to x9; a D instruction reading x9 stalls until `mc_done` with `mc_dst = 9`, then proceeds the next cycle. `stall_cnt` equals the stall cycles.
- Structural: two issues with `MC_OUTSTANDING = 2` → a third `mc_start_d` stalls until one `mc_done`. Simultaneous issue and done keeps `count = 2`.
- Priority: `mem_wait` with `pc_redirect_e` and a load-use condition → only the four stalls and `flush_w` are high. Drop `mem_wait` → `flush_d`/`flush_e` high and `stall_f` low.
- Reset: assert `rst` mid-op with `count = 1` → `pending = 0`, `count = 0`, `stall_cnt = 0`, all outputs 0. A later `mc_done` leaves `count = 0`.
